vga_frame_fetch_ctrl: RTL

Frame fetch controller that feeds the VGA line FIFO from the external frame buffer. It accepts the display timing generator's per-frame `read_req`/`read_req_ack` handshake and flushes the pixel FIFO. It then issues fixed-length read bursts to the memory arbiter whenever the FIFO has room, until one full frame has been fetched. It sits between the VGA driver's pixel FIFO (write side) and the frame-buffer memory arbiter's read port.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_frame_fetch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding and default geometry for the VGA frame fetch path
//
// Contents:
//   fetch_state_t   - frame fetch controller state encoding
//   H_RES, V_RES    - default display resolution
//   *_DEF           - default parameter values for vga_frame_fetch_ctrl
//   min_u           - unsigned minimum helper
package vga_pkg;

    localparam int H_RES           = 640;
    localparam int V_RES           = 480;
    localparam int FRAME_WORDS_DEF = H_RES * V_RES;
    localparam int BURST_LEN_DEF   = 64;
    localparam int FIFO_DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF      = 24;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH      = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_REQ        = 3'd3,
        ST_XFER       = 3'd4,
        ST_DONE       = 3'd5
    } fetch_state_t;

    function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_frame_fetch_ctrl.sv
// rtl/vga_frame_fetch_ctrl.sv - fetches one frame from the frame buffer into the VGA pixel FIFO
//
// Optional feature: define VGA_DOUBLE_BUF_EN to display from two alternating
// frame buffers, switching at a frame start after the camera writer finished a frame.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   read_req/read_req_ack - per-frame start handshake with the timing generator
//   base_addr0/1          - frame buffer base word addresses
//   wr_frame_done         - camera writer end-of-frame pulse
//   fifo_wrusedw          - pixel FIFO fill level (write side)
//   fifo_clr              - one-cycle FIFO flush at frame start
//   fifo_wr_en/_data      - FIFO write port, fed straight from read data
//   rd_burst_req/grant    - burst request handshake with the memory arbiter
//   rd_burst_addr/len     - burst start address and length, stable while requesting
//   rd_burst_data_valid/data/finish - arbiter read data return
//   frame_active          - high from frame acceptance until the last burst finishes
module vga_frame_fetch_ctrl
    import vga_pkg::*;
#(
    parameter  int ADDR_W      = ADDR_W_DEF,
    parameter  int BURST_LEN   = BURST_LEN_DEF,
    parameter  int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    localparam int USEDW_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int LEN_W       = $clog2(BURST_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_req,
    output logic               read_req_ack,
    input  logic [ADDR_W-1:0]  base_addr0,
    input  logic [ADDR_W-1:0]  base_addr1,
    input  logic               wr_frame_done,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    output logic               fifo_clr,
    output logic               fifo_wr_en,
    output logic [15:0]        fifo_wr_data,
    output logic               rd_burst_req,
    input  logic               rd_burst_grant,
    output logic [ADDR_W-1:0]  rd_burst_addr,
    output logic [LEN_W-1:0]   rd_burst_len,
    input  logic               rd_burst_data_valid,
    input  logic [15:0]        rd_burst_data,
    input  logic               rd_burst_finish,
    output logic               frame_active
);

    localparam int REM_W = $clog2(FRAME_WORDS + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] addr;
    logic [REM_W-1:0]  remain;
    logic              restart_pend;

    logic [ADDR_W-1:0] active_base;
    logic [LEN_W-1:0]  len;
    logic              space_ok;
    logic              start_frame;
    logic              last_burst;

    // Next burst length: a full burst, or whatever is left of the frame.
    assign len = LEN_W'(min_u(32'(remain), 32'(BURST_LEN)));

    // Evaluated at 32 bits so fill level + burst length cannot wrap.
    assign space_ok = (32'(fifo_wrusedw) + 32'(len)) <= 32'(FIFO_DEPTH);

    // A held read_req is taken as a new frame whenever no burst is in flight
    // and the FIFO clear is not still settling.
    assign start_frame = read_req &&
                         ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_WAIT_SPACE));

    assign last_burst = (remain == REM_W'(rd_burst_len));

`ifdef VGA_DOUBLE_BUF_EN
    logic disp_sel;
    logic swap_pend;
    logic swap_now;

    // A writer end-of-frame in the same cycle as the frame start still counts.
    assign swap_now    = swap_pend | wr_frame_done;
    assign active_base = (disp_sel ^ swap_now) ? base_addr1 : base_addr0;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sel  <= 1'b0;
            swap_pend <= 1'b0;
        end else if (start_frame) begin
            disp_sel  <= disp_sel ^ swap_now;
            swap_pend <= 1'b0;
        end else begin
            swap_pend <= swap_now;
        end
    end
`else
    logic unused_dbuf_inputs;

    assign active_base        = base_addr0;
    assign unused_dbuf_inputs = wr_frame_done ^ (^base_addr1);
`endif

    // Read data goes to the FIFO with no register stage; data arriving
    // outside a transfer (e.g. after a reset) is dropped.
    assign fifo_wr_en   = (state == ST_XFER) && rd_burst_data_valid;
    assign fifo_wr_data = fifo_wr_en ? rd_burst_data : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remain        <= '0;
            restart_pend  <= 1'b0;
            read_req_ack  <= 1'b0;
            fifo_clr      <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            rd_burst_len  <= '0;
            frame_active  <= 1'b0;
        end else begin
            read_req_ack <= 1'b0;
            fifo_clr     <= 1'b0;

            if (start_frame) begin
                read_req_ack <= 1'b1;
                fifo_clr     <= 1'b1;
                addr         <= active_base;
                remain       <= REM_W'(FRAME_WORDS);
                restart_pend <= 1'b0;
                frame_active <= 1'b1;
                state        <= ST_FLUSH;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        state <= state;
                    end

                    ST_FLUSH: begin
                        state <= ST_WAIT_SPACE;
                    end

                    ST_WAIT_SPACE: begin
                        // Only one burst is ever outstanding, so the fill
                        // level alone says whether this burst will fit.
                        if (space_ok) begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_addr <= addr;
                            rd_burst_len  <= len;
                            state         <= ST_REQ;
                        end
                    end

                    ST_REQ: begin
                        // The arbiter cannot retract a request, so a restart
                        // waits for this burst to run to completion.
                        if (read_req) begin
                            restart_pend <= 1'b1;
                        end
                        if (rd_burst_grant) begin
                            rd_burst_req <= 1'b0;
                            state        <= ST_XFER;
                        end
                    end

                    ST_XFER: begin
                        if (read_req) begin
                            restart_pend <= 1'b1;
                        end
                        if (rd_burst_finish) begin
                            addr   <= addr + ADDR_W'(rd_burst_len);
                            remain <= remain - REM_W'(rd_burst_len);
                            if (restart_pend || read_req) begin
                                // The held read_req is acknowledged from IDLE,
                                // whose fifo_clr discards this burst's data.
                                restart_pend <= 1'b0;
                                frame_active <= 1'b0;
                                state        <= ST_IDLE;
                            end else if (last_burst) begin
                                frame_active <= 1'b0;
                                state        <= ST_DONE;
                            end else begin
                                state <= ST_WAIT_SPACE;
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
